// File: rtl/quant_sched.sv
// Requantization scheduler: looks up per-channel (M, n), issues beats to a fixed-latency
// quantizer, and wraps its output in a credit-throttled skid FIFO with ready/valid semantics.
module quant_sched #(
  parameter int NUM_CH     = 64,
  parameter int Q_LAT      = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_addr,
  input  logic [31:0]     cfg_M,
  input  logic [4:0]      cfg_n,
  input  logic [CH_W:0]   cfg_num_ch,
  output logic            cfg_err,
  input  logic            start,
  output logic            busy,
  output logic            done,
  input  logic [31:0]     acc_data,
  input  logic            acc_valid,
  input  logic            acc_last,
  output logic            acc_ready,
  output logic [31:0]     q_data_in,
  output logic            q_valid_in,
  output logic [31:0]     q_M,
  output logic [4:0]      q_n,
  input  logic [7:0]      q_data_out,
  input  logic            q_valid_out,
  output logic [7:0]      out_data,
  output logic            out_valid,
  output logic            out_last,
  input  logic            out_ready,
  output logic [1:0]      dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid & ready are both high;
  // valid never depends on ready, and data is held stable while valid waits.

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IF_W  = PTR_W + 1;
  localparam int CR_W  = IF_W + 2;

  localparam logic [CH_W:0]   NUM_ONE = 1;
  localparam logic [CH_W-1:0] CH_ONE  = 1;
  localparam logic [IF_W-1:0] IF_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CH_W:0]   NUM_MAX = NUM_CH;
  localparam logic [CR_W-1:0] CR_MAX  = FIFO_DEPTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W:0]     num_ch_q;
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [IF_W-1:0]   inflight_q, inflight_d;
  logic [31:0]       tbl_m_q [NUM_CH];
  logic [4:0]        tbl_n_q [NUM_CH];
  logic              q_valid_q, q_last_q;
  logic [31:0]       q_data_q, q_m_q;
  logic [4:0]        q_n_q;
  logic [Q_LAT-1:0]  last_sr_q;
  logic [8:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [IF_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic              num_ok, start_go, accept, push, pop, fifo_empty;
  logic [CR_W-1:0]   credit_used;

  assign num_ok     = (cfg_num_ch != '0) && (cfg_num_ch <= NUM_MAX);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign push       = q_valid_out;
  assign pop        = out_valid && out_ready;
  assign accept     = acc_valid && acc_ready;

  // A beat accepted last cycle is on q_valid_in now but not yet counted in inflight_q.
  assign credit_used = CR_W'(inflight_q) + CR_W'(fifo_cnt_q) + CR_W'(q_valid_q);
  assign acc_ready   = (state_q == S_RUN) && (credit_used < CR_MAX);

  always_comb begin
    state_d  = state_q;
    done     = 1'b0;
    start_go = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && num_ok) begin
          state_d  = S_RUN;
          start_go = 1'b1;
        end
      end
      S_RUN: begin
        if (accept && acc_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((inflight_q == '0) && fifo_empty && !q_valid_q) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;
  assign cfg_err   = !rst && ((cfg_we && (state_q != S_IDLE)) ||
                              (start && (state_q == S_IDLE) && !num_ok));

  always_comb begin
    ch_cnt_d = ch_cnt_q;
    if (start_go) begin
      ch_cnt_d = '0;
    end else if (accept) begin
      if (acc_last || ({1'b0, ch_cnt_q} == (num_ch_q - NUM_ONE))) ch_cnt_d = '0;
      else ch_cnt_d = ch_cnt_q + CH_ONE;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (q_valid_q && !q_valid_out) inflight_d = inflight_q + IF_ONE;
    else if (!q_valid_q && q_valid_out) inflight_d = inflight_q - IF_ONE;
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) fifo_cnt_d = fifo_cnt_q + IF_ONE;
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - IF_ONE;
  end

  // Table and FIFO storage carry no reset; only pointers and counters are cleared.
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == S_IDLE)) begin
      tbl_m_q[cfg_addr] <= cfg_M;
      tbl_n_q[cfg_addr] <= cfg_n;
    end
    if (push) fifo_mem_q[wr_ptr_q] <= {last_sr_q[Q_LAT-1], q_data_out};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      num_ch_q   <= '0;
      ch_cnt_q   <= '0;
      inflight_q <= '0;
      q_valid_q  <= 1'b0;
      q_last_q   <= 1'b0;
      q_data_q   <= '0;
      q_m_q      <= '0;
      q_n_q      <= '0;
      last_sr_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ch_cnt_q   <= ch_cnt_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      q_valid_q  <= accept;
      if (start_go) num_ch_q <= cfg_num_ch;
      if (accept) begin
        q_data_q <= acc_data;
        q_m_q    <= tbl_m_q[ch_cnt_q];
        q_n_q    <= tbl_n_q[ch_cnt_q];
        q_last_q <= acc_last;
      end
      // The last tag shifts alongside the quantizer pipeline so it lands with q_valid_out.
      last_sr_q <= Q_LAT'({last_sr_q, q_valid_q & q_last_q});
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  assign q_valid_in = q_valid_q;
  assign q_data_in  = q_data_q;
  assign q_M        = q_m_q;
  assign q_n        = q_n_q;
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? 8'd0 : fifo_mem_q[rd_ptr_q][7:0];
  assign out_last   = fifo_empty ? 1'b0 : fifo_mem_q[rd_ptr_q][8];

endmodule

// File: tb/tb_quant_sched.sv
// Bench for quant_sched: stand-in quantizer, arithmetic reference model with expected
// queues, table-driven config vectors and directed multi-cycle sequences.
module tb_quant_sched;
  localparam int NUM_CH     = 64;
  localparam int Q_LAT      = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int CH_W       = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we, start, acc_valid, acc_last, out_ready;
  logic [CH_W-1:0] cfg_addr;
  logic [31:0]     cfg_M, acc_data;
  logic [4:0]      cfg_n;
  logic [CH_W:0]   cfg_num_ch;
  logic            cfg_err, busy, done, acc_ready;
  logic [31:0]     q_data_in, q_M;
  logic [4:0]      q_n;
  logic            q_valid_in, q_valid_out;
  logic [7:0]      q_data_out, out_data;
  logic            out_valid, out_last;
  logic [1:0]      dbg_state;

  quant_sched #(.NUM_CH(NUM_CH), .Q_LAT(Q_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_M(cfg_M), .cfg_n(cfg_n),
    .cfg_num_ch(cfg_num_ch), .cfg_err(cfg_err),
    .start(start), .busy(busy), .done(done),
    .acc_data(acc_data), .acc_valid(acc_valid), .acc_last(acc_last), .acc_ready(acc_ready),
    .q_data_in(q_data_in), .q_valid_in(q_valid_in), .q_M(q_M), .q_n(q_n),
    .q_data_out(q_data_out), .q_valid_out(q_valid_out),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0]  exp_q[$];
  logic [68:0] iss_q[$];
  logic [8:0]  got_q[$];
  logic [4:0]  qn_log[$];
  int done_cnt = 0;
  int occ      = 0;
  logic [31:0] ref_m [NUM_CH];
  logic [4:0]  ref_n [NUM_CH];
  int ref_ch  = 0;
  int ref_num = 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stand-in quantizer: saturate((acc * M) >> (n + 2)) to int8.
  function automatic logic [7:0] quant(input logic [31:0] a, input logic [31:0] m,
                                       input logic [4:0] n);
    longint p;
    p = longint'($signed(a)) * longint'({32'b0, m});
    p = p >>> (n + 2);
    if (p > 127) return 8'h7f;
    if (p < -128) return 8'h80;
    return p[7:0];
  endfunction

  logic       qpv [Q_LAT];
  logic [7:0] qpd [Q_LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Q_LAT; i++) qpv[i] <= 1'b0;
    end else begin
      qpv[0] <= q_valid_in;
      qpd[0] <= quant(q_data_in, q_M, q_n);
      for (int i = 1; i < Q_LAT; i++) begin
        qpv[i] <= qpv[i-1];
        qpd[i] <= qpd[i-1];
      end
    end
  end
  assign q_valid_out = qpv[Q_LAT-1];
  assign q_data_out  = qpd[Q_LAT-1];

  // ---------------- scoreboard / reference model ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (acc_valid && acc_ready) begin
        exp_q.push_back({acc_last, quant(acc_data, ref_m[ref_ch], ref_n[ref_ch])});
        iss_q.push_back({acc_data, ref_m[ref_ch], ref_n[ref_ch]});
        ref_ch = acc_last ? 0 : (ref_ch + 1) % ref_num;
      end
      if (q_valid_in) begin
        qn_log.push_back(q_n);
        if (iss_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL issue_unexpected: got q_data_in %0h with nothing expected", q_data_in);
        end else begin
          chk("issue_data_M_n", {q_data_in, q_M, q_n}, iss_q.pop_front());
        end
      end
      if (q_valid_out) begin
        n_tests++;
        if (occ >= FIFO_DEPTH) begin
          n_fail++;
          $display("FAIL fifo_overflow: push with occupancy %0d, limit %0d", occ, FIFO_DEPTH);
        end
      end
      if (out_valid && out_ready) begin
        got_q.push_back({out_last, out_data});
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL out_unexpected: got %0h with nothing expected", {out_last, out_data});
        end else begin
          chk("out_last_data", {out_last, out_data}, exp_q.pop_front());
        end
      end
      occ = occ + (q_valid_out ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input logic [31:0] m, input logic [4:0] n,
                           input bit in_idle);
    cfg_we = 1'b1; cfg_addr = CH_W'(addr); cfg_M = m; cfg_n = n;
    #1;
    chk("cfg_write_err", cfg_err, !in_idle);
    if (in_idle) begin
      ref_m[addr] = m;
      ref_n[addr] = n;
    end
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_tile(input int num);
    cfg_num_ch = 7'(num); start = 1'b1;
    #1;
    chk("start_err", cfg_err, 1'b0);
    tick();
    start = 1'b0;
    ref_num = num;
    ref_ch = 0;
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic send_beats(input int n, input int vpct, input bit toggle_rdy,
                            input bit fixed, input logic [31:0] fdata);
    int sent = 0;
    int cyc = 0;
    while (sent < n && cyc < n * 30 + 50) begin
      acc_valid = ($urandom_range(0, 99) < vpct);
      if (fixed) acc_data = fdata;
      else if ($urandom_range(0, 3) != 0) acc_data = 32'($urandom_range(0, 4000)) - 32'd2000;
      else acc_data = $urandom;
      acc_last = (sent == n - 1);
      if (toggle_rdy) out_ready = ~out_ready;
      if (acc_valid && acc_ready) sent++;
      tick();
      cyc++;
    end
    acc_valid = 1'b0;
    acc_last = 1'b0;
    chk("beats_sent", sent, n);
  endtask

  task automatic wait_idle(input int budget);
    int cyc = 0;
    out_ready = 1'b1;
    while (busy && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("idle_reached", busy, 1'b0);
  endtask

  task automatic wait_drained(input int budget);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("drained", exp_q.size(), 0);
  endtask

  // ---------------- config vectors ----------------
  typedef struct {
    string      name;
    logic       we;
    logic       st;
    logic [6:0] num;
    logic       exp_err;
    logic       exp_busy;
  } vec_t;
  vec_t vt[6];

  int acc_cnt3;
  int got0;
  int done0;
  int exp_n[9];

  initial begin
    vt[0] = '{"start_num_0",   1'b0, 1'b1, 7'd0,   1'b1, 1'b0};
    vt[1] = '{"start_num_65",  1'b0, 1'b1, 7'd65,  1'b1, 1'b0};
    vt[2] = '{"start_num_127", 1'b0, 1'b1, 7'd127, 1'b1, 1'b0};
    vt[3] = '{"cfg_we_idle",   1'b1, 1'b0, 7'd0,   1'b0, 1'b0};
    vt[4] = '{"start_num_1",   1'b0, 1'b1, 7'd1,   1'b0, 1'b1};
    vt[5] = '{"start_num_64",  1'b0, 1'b1, 7'd64,  1'b0, 1'b1};
    exp_n = '{3, 5, 7, 3, 5, 7, 3, 3, 5};

    rst = 1'b1; cfg_we = 1'b0; start = 1'b0; acc_valid = 1'b0; acc_last = 1'b0;
    out_ready = 1'b1; cfg_addr = '0; cfg_M = '0; cfg_n = '0; cfg_num_ch = '0; acc_data = '0;
    #1;
    chk("reset_outputs", {acc_ready, q_valid_in, q_data_in, q_M, q_n, out_data, out_valid,
                          out_last, busy, done, cfg_err, dbg_state}, '0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < NUM_CH; i++)
      cfg_write(i, $urandom & 32'h7fff_ffff, 5'($urandom_range(0, 31)), 1'b1);

    // Config/start vectors, each applied in IDLE.
    for (int v = 0; v < 6; v++) begin
      cfg_we = vt[v].we; start = vt[v].st; cfg_num_ch = vt[v].num;
      cfg_addr = 6'd5; cfg_M = 32'h0bad_f00d; cfg_n = 5'd9;
      #1;
      chk({vt[v].name, "_err"}, cfg_err, vt[v].exp_err);
      if (vt[v].we) begin
        ref_m[5] = 32'h0bad_f00d;
        ref_n[5] = 5'd9;
      end
      tick();
      cfg_we = 1'b0; start = 1'b0;
      chk({vt[v].name, "_busy"}, busy, vt[v].exp_busy);
      if (vt[v].exp_busy) begin
        ref_num = int'(vt[v].num);
        ref_ch = 0;
        send_beats(1, 100, 1'b0, 1'b0, 32'd0);
        wait_idle(200);
      end
    end

    // Two-beat tile with known requantization pairs.
    cfg_write(0, 32'h4000_0000, 5'd30, 1'b1);
    cfg_write(1, 32'h4000_0000, 5'd29, 1'b1);
    got_q.delete();
    done0 = done_cnt;
    start_tile(2);
    send_beats(2, 100, 1'b0, 1'b1, 32'd100);
    wait_idle(200);
    chk("t1_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t1_beat0", got_q[0], {1'b0, 8'd25});
      chk("t1_beat1", got_q[1], {1'b1, 8'd50});
    end
    chk("t1_done_pulses", done_cnt - done0, 1);

    // Channel rotation over 3 channels, then a fresh tile restarting at channel 0.
    cfg_write(0, 32'h1111_0000, 5'd3, 1'b1);
    cfg_write(1, 32'h2222_0000, 5'd5, 1'b1);
    cfg_write(2, 32'h3333_0000, 5'd7, 1'b1);
    qn_log.delete();
    start_tile(3);
    send_beats(7, 100, 1'b0, 1'b0, 32'd0);
    wait_idle(200);
    start_tile(3);
    send_beats(2, 100, 1'b0, 1'b0, 32'd0);
    wait_idle(200);
    chk("chan_log_len", qn_log.size(), 9);
    if (qn_log.size() == 9)
      for (int i = 0; i < 9; i++) chk("chan_seq_n", qn_log[i], 5'(exp_n[i]));

    // Table write attempt while running must be refused.
    start_tile(2);
    cfg_write(0, 32'hdead_beef, 5'd1, 1'b0);
    chk("cfg_we_run_busy", busy, 1'b1);
    send_beats(2, 100, 1'b0, 1'b0, 32'd0);
    wait_idle(200);

    // Backpressure: downstream stalled, stream held valid.
    out_ready = 1'b0;
    got_q.delete();
    start_tile(4);
    acc_cnt3 = 0;
    for (int i = 0; i < 20; i++) begin
      acc_valid = 1'b1; acc_last = 1'b0; acc_data = $urandom;
      if (acc_ready) acc_cnt3++;
      tick();
    end
    chk("stall_accepts", acc_cnt3, FIFO_DEPTH);
    chk("stall_ready_low", acc_ready, 1'b0);
    acc_valid = 1'b0;
    out_ready = 1'b1;
    wait_drained(100);
    chk("stall_delivered", got_q.size(), FIFO_DEPTH);
    send_beats(1, 100, 1'b0, 1'b0, 32'd0);
    wait_idle(200);

    // Random tiles with out_ready toggling every cycle.
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 4; k++)
        cfg_write($urandom_range(0, NUM_CH - 1), $urandom & 32'h7fff_ffff,
                  5'($urandom_range(0, 31)), 1'b1);
      start_tile($urandom_range(1, NUM_CH));
      send_beats($urandom_range(5, 60), 70, 1'b1, 1'b0, 32'd0);
      wait_idle(400);
    end

    // Reset in the middle of a tile with beats in flight.
    start_tile(2);
    send_beats(3, 100, 1'b0, 1'b0, 32'd0);
    acc_valid = 1'b1;
    rst = 1'b1; start = 1'b1; cfg_num_ch = '0;
    #1;
    chk("midreset_outputs", {acc_ready, q_valid_in, q_data_in, q_M, q_n, out_data, out_valid,
                             out_last, busy, done, cfg_err}, '0);
    exp_q.delete(); iss_q.delete(); occ = 0;
    acc_valid = 1'b0; start = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("postreset_out_valid", out_valid, 1'b0);
    chk("postreset_busy", busy, 1'b0);
    got_q.delete();
    start_tile(3);
    send_beats(5, 100, 1'b0, 1'b0, 32'd0);
    wait_idle(200);
    chk("postreset_count", got_q.size(), 5);

    repeat (10) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("issue_queue_empty", iss_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
